// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache slice.
//   icacheState_t          : refill controller state (IDLE / REFILL)
//   ICACHE_NUM_LINES       : default number of direct-mapped lines
//   ICACHE_WORDS_PER_LINE  : default number of 32-bit words per line
package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } icacheState_t;

    localparam int unsigned ICACHE_NUM_LINES      = 16;
    localparam int unsigned ICACHE_WORDS_PER_LINE = 4;

endpackage

// File: rtl/icache_data_array.sv
// Instruction cache data storage, one 32-bit word per (line, word) slot.
//   clk     : write clock
//   wrEn    : write one word on the rising edge
//   wrIndex : line being written
//   wrWord  : word within the line being written
//   wrData  : word value
//   rdIndex : line being read (asynchronous)
//   rdWord  : word within the line being read
//   rdData  : word at (rdIndex, rdWord)
// Contents are not reset; validity is tracked by the owner.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES      = ICACHE_NUM_LINES,
    parameter int unsigned WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
    input  logic                              clk,
    input  logic                              wrEn,
    input  logic [$clog2(NUM_LINES)-1:0]      wrIndex,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wrWord,
    input  logic [31:0]                       wrData,
    input  logic [$clog2(NUM_LINES)-1:0]      rdIndex,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rdWord,
    output logic [31:0]                       rdData
);

    logic [31:0] words [NUM_LINES][WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            words[wrIndex][wrWord] <= wrData;
        end
    end

    assign rdData = words[rdIndex][rdWord];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with a blocking line refill.
//   clk       : clock, all state on the rising edge
//   rst       : synchronous active-high reset
//   cpu_req   : fetch request at cpu_addr
//   cpu_addr  : byte address of the fetch (bits [1:0] ignored)
//   cpu_instr : fetched word, valid when cpu_req=1 and cpu_stall=0
//   cpu_stall : hold PC and IF/ID
//   flush     : invalidate all lines (fence.i)
//   mem_req   : refill in progress, request to backing memory
//   mem_addr  : line-aligned refill base address
//   mem_valid : one refill beat present on mem_rdata
//   mem_rdata : refill beat, ascending word order
// Tag/valid storage and the refill FSM live here; words live in
// icache_data_array.
module instr_cache
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES      = ICACHE_NUM_LINES,
    parameter int unsigned WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_instr,
    output logic        cpu_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned LINE_W = 32 - 2 - OFF_W;
    localparam int unsigned TAG_W  = LINE_W - IDX_W;

    icacheState_t         state;
    logic [LINE_W-1:0]    missLine;
    logic [OFF_W-1:0]     beatCnt;
    logic                 flushPending;
    logic [NUM_LINES-1:0] lineValid;
    logic [TAG_W-1:0]     tagArr [NUM_LINES];

    logic [OFF_W-1:0] reqOffset;
    logic [IDX_W-1:0] reqIndex;
    logic [TAG_W-1:0] reqTag;
    logic [IDX_W-1:0] missIndex;
    logic [TAG_W-1:0] missTag;
    logic             lookupHit;
    logic             beatWrite;
    logic             lastBeat;
    logic             unusedAddrBits;

    assign reqOffset = cpu_addr[2 +: OFF_W];
    assign reqIndex  = cpu_addr[2 + OFF_W +: IDX_W];
    assign reqTag    = cpu_addr[31 -: TAG_W];
    assign missIndex = missLine[IDX_W-1:0];
    assign missTag   = missLine[LINE_W-1:IDX_W];
    assign unusedAddrBits = ^cpu_addr[1:0];

    assign lookupHit = (state == IDLE) && cpu_req && lineValid[reqIndex]
                       && (tagArr[reqIndex] == reqTag);
    assign beatWrite = (state == REFILL) && mem_valid;
    assign lastBeat  = beatWrite && (beatCnt == OFF_W'(WORDS_PER_LINE - 1));

    assign cpu_stall = (state == REFILL) || (cpu_req && !lookupHit);
    assign mem_req   = (state == REFILL);
    assign mem_addr  = {missLine, {(2 + OFF_W){1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lineValid    <= '0;
            flushPending <= 1'b0;
            beatCnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Lookup above already used the pre-flush valid bits.
                    if (flush) begin
                        lineValid <= '0;
                    end
                    if (cpu_req && !lookupHit) begin
                        missLine <= cpu_addr[31:2 + OFF_W];
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flushPending <= 1'b1;
                    end
                    if (mem_valid) begin
                        beatCnt <= beatCnt + 1'b1;
                    end
                    if (lastBeat) begin
                        state        <= IDLE;
                        beatCnt      <= '0;
                        flushPending <= 1'b0;
                        // A flush seen on the final edge counts as pending too.
                        if (flushPending || flush) begin
                            lineValid <= '0;
                        end else begin
                            lineValid[missIndex] <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (lastBeat && !rst) begin
            tagArr[missIndex] <= missTag;
        end
    end

    icache_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) dataArray (
        .clk     (clk),
        .wrEn    (beatWrite),
        .wrIndex (missIndex),
        .wrWord  (beatCnt),
        .wrData  (mem_rdata),
        .rdIndex (reqIndex),
        .rdWord  (reqOffset),
        .rdData  (cpu_instr)
    );

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache at default geometry (16 lines x 4 words).
// A memory responder serves refills from a fixed address->word function; a
// line-granular reference model predicts hits, stall lengths and data.
module tb_instr_cache;

    localparam int WPL        = 4;
    localparam int NL         = 16;
    localparam int LINE_BYTES = WPL * 4;

    localparam int ACT_NONE       = 0;
    localparam int ACT_FLUSH      = 1;
    localparam int ACT_RST        = 2;
    localparam int ACT_CHG        = 3;
    localparam int ACT_FLUSH_IDLE = 4;

    typedef struct {
        logic [31:0] addr;
        int          action;
        int          actBeat;
        logic [31:0] altAddr;
        int          period;
        int          expStalls;
        logic [31:0] expInstr;
        bit          chkInstr;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    int srvPeriod  = 1;
    int srvBeat    = 0;
    int srvPhase   = 0;
    bit srvReqPrev = 0;

    bit          refValid [NL];
    logic [31:0] refBase  [NL];

    vec_t vecs[$];

    instr_cache #(
        .NUM_LINES      (NL),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_instr (cpu_instr),
        .cpu_stall (cpu_stall),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        case (w)
            32'h0: return 32'h0050_0093;
            32'h4: return 32'h0010_0113;
            32'h8: return 32'h0020_81B3;
            32'hC: return 32'h0000_0013;
            default: return w * 32'h9E37_79B1 + 32'h1357_2468;
        endcase
    endfunction

    function automatic logic [31:0] lineBase(input logic [31:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic int lineIdx(input logic [31:0] a);
        return int'((a / LINE_BYTES) % NL);
    endfunction

    function automatic bit predictHit(input logic [31:0] a);
        return refValid[lineIdx(a)] && (refBase[lineIdx(a)] == lineBase(a));
    endfunction

    task automatic clearModel();
        for (int i = 0; i < NL; i++) refValid[i] = 1'b0;
    endtask

    task automatic modelUpdate(input logic [31:0] a, input int action, input bit wasHit);
        if (action == ACT_FLUSH || action == ACT_RST) begin
            clearModel();
        end else begin
            if (action == ACT_FLUSH_IDLE) clearModel();
            if (!(action == ACT_FLUSH_IDLE && wasHit)) begin
                refValid[lineIdx(a)] = 1'b1;
                refBase[lineIdx(a)]  = lineBase(a);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Refill responder: beats ascend from mem_addr; random noise while idle.
    initial begin
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (srvReqPrev && mem_valid) srvBeat++;
            #1;
            if (!mem_req) begin
                srvBeat   = 0;
                srvPhase  = 0;
                mem_valid = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end else begin
                srvPhase++;
                mem_valid = (srvPhase % srvPeriod) == 0;
                mem_rdata = mem_valid ? memWord(mem_addr + 32'(4 * srvBeat)) : $urandom;
            end
            srvReqPrev = mem_req;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Entered and left at a falling edge.
    task automatic doFetch(input vec_t v);
        int   stalls;
        int   iter;
        bit   acted, sawReq, sawAlt, sawReturnMiss, done, timedOut, rstWas;
        logic [31:0] base;
        stalls = 0; iter = 0;
        acted = 0; sawReq = 0; sawAlt = 0; sawReturnMiss = 0; done = 0; timedOut = 0;
        base      = lineBase(v.addr);
        srvPeriod = v.period;
        cpu_addr  = v.addr;
        cpu_req   = 1'b1;
        if (v.action == ACT_FLUSH_IDLE) flush = 1'b1;
        #2;
        while (!done) begin
            iter++;
            if (iter > 100) begin
                timedOut = 1;
                done     = 1;
                check({v.name, "_timeout"}, 32'(iter), 32'd100);
            end else if (!cpu_stall) begin
                done = 1;
            end else if (!mem_req && sawReq && v.action == ACT_FLUSH) begin
                sawReturnMiss = 1;
                cpu_req = 1'b0;
                #1;
                done = 1;
            end else if (!mem_req && sawReq && v.action == ACT_CHG && !sawAlt) begin
                // Line for the original address is done; alternate misses here.
                sawAlt   = 1;
                cpu_addr = v.addr;
                #1;
            end else begin
                if (mem_req) begin
                    sawReq = 1;
                    check({v.name, "_memaddr"}, mem_addr, base);
                end
                if (mem_req && mem_valid && srvBeat == v.actBeat && !acted &&
                    v.action inside {ACT_FLUSH, ACT_RST, ACT_CHG}) begin
                    acted = 1;
                    case (v.action)
                        ACT_FLUSH: flush    = 1'b1;
                        ACT_RST:   rst      = 1'b1;
                        default:   cpu_addr = v.altAddr;
                    endcase
                end
                stalls++;
                @(negedge clk);
                flush  = 1'b0;
                rstWas = rst;
                rst    = 1'b0;
                #2;
                if (rstWas) begin
                    check({v.name, "_memreq_drop"}, 32'(mem_req), 32'd0);
                    done = 1;
                end
            end
        end
        check({v.name, "_stalls"}, 32'(stalls), 32'(v.expStalls));
        if (v.chkInstr && !timedOut) check({v.name, "_instr"}, cpu_instr, v.expInstr);
        if (v.action == ACT_FLUSH) check({v.name, "_return_miss"}, 32'(sawReturnMiss), 32'd1);
        if (v.action == ACT_CHG)   check({v.name, "_alt_miss"}, 32'(sawAlt), 32'd1);
        if (v.action == ACT_RST)   check({v.name, "_rst_fired"}, 32'(acted), 32'd1);
        cpu_req = 1'b0;
        #1;
        check({v.name, "_idle_stall"}, 32'(cpu_stall), 32'd0);
        check({v.name, "_idle_memreq"}, 32'(mem_req), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic addVec(input logic [31:0] addr, input int action, input int actBeat,
                          input logic [31:0] altAddr, input int period, input int expStalls,
                          input logic [31:0] expInstr, input bit chkInstr, input string name);
        vec_t v;
        v.addr = addr; v.action = action; v.actBeat = actBeat; v.altAddr = altAddr;
        v.period = period; v.expStalls = expStalls; v.expInstr = expInstr;
        v.chkInstr = chkInstr; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t v;
        bit   hit;
        rst      = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        flush    = 1'b0;
        clearModel();

        addVec(32'h000, ACT_NONE,  0, 0, 1, 5,  32'h0050_0093, 1, "r032_miss");
        addVec(32'h00C, ACT_NONE,  0, 0, 1, 0,  32'h0000_0013, 1, "r032_hit");
        addVec(32'h004, ACT_NONE,  0, 0, 1, 0,  32'h0010_0113, 1, "r032_hit_w1");
        addVec(32'h100, ACT_NONE,  0, 0, 1, 5,  memWord(32'h100), 1, "r033_conflict");
        addVec(32'h008, ACT_NONE,  0, 0, 1, 5,  32'h0020_81B3, 1, "r033_refetch");
        addVec(32'h030, ACT_NONE,  0, 0, 3, 13, memWord(32'h030), 1, "r034_slow");
        addVec(32'h034, ACT_NONE,  0, 0, 1, 0,  memWord(32'h034), 1, "r034_w1");
        addVec(32'h03B, ACT_NONE,  0, 0, 1, 0,  memWord(32'h038), 1, "r034_w2");
        addVec(32'h03C, ACT_NONE,  0, 0, 1, 0,  memWord(32'h03C), 1, "r034_w3");
        addVec(32'h040, ACT_FLUSH, 1, 0, 1, 5,  0, 0, "r035_flush");
        addVec(32'h040, ACT_NONE,  0, 0, 1, 5,  memWord(32'h040), 1, "r035_refetch");
        addVec(32'h000, ACT_NONE,  0, 0, 1, 5,  32'h0050_0093, 1, "r035_old");
        addVec(32'h080, ACT_RST,   2, 0, 1, 4,  0, 0, "r036_rst");
        addVec(32'h084, ACT_NONE,  0, 0, 1, 5,  memWord(32'h084), 1, "r036_refill");
        addVec(32'h010, ACT_CHG,   1, 32'h200, 1, 5, memWord(32'h010), 1, "r037_chg");
        addVec(32'h200, ACT_NONE,  0, 0, 1, 5,  memWord(32'h200), 1, "r037_alt");
        addVec(32'h014, ACT_NONE,  0, 0, 1, 0,  memWord(32'h014), 1, "r037_line");
        addVec(32'h018, ACT_FLUSH_IDLE, 0, 0, 1, 0, memWord(32'h018), 1, "flush_idle_hit");
        addVec(32'h01C, ACT_NONE,  0, 0, 1, 5,  memWord(32'h01C), 1, "after_flush_idle");

        repeat (3) @(negedge clk);
        #2;
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_memreq", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("post_rst_stall", 32'(cpu_stall), 32'd0);
        check("post_rst_memreq", 32'(mem_req), 32'd0);
        @(negedge clk);

        foreach (vecs[i]) begin
            hit = predictHit(vecs[i].addr);
            doFetch(vecs[i]);
            modelUpdate(vecs[i].addr, vecs[i].action, hit);
        end

        for (int n = 0; n < 200; n++) begin
            v.addr = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                     (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            v.period  = $urandom_range(1, 3);
            v.altAddr = '0;
            v.actBeat = $urandom_range(0, WPL - 1);
            hit = predictHit(v.addr);
            v.expStalls = hit ? 0 : 1 + WPL * v.period;
            if (!hit && $urandom_range(0, 15) == 0) v.action = ACT_FLUSH;
            else if ($urandom_range(0, 15) == 0)   v.action = ACT_FLUSH_IDLE;
            else                                   v.action = ACT_NONE;
            v.chkInstr = (v.action != ACT_FLUSH);
            v.expInstr = memWord(v.addr);
            v.name     = $sformatf("rnd%0d", n);
            doFetch(v);
            modelUpdate(v.addr, v.action, hit);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 Parameter NUM_LINES, default 16, number of direct-mapped lines; power of two, at least 2.
REQ-002 Parameter WORDS_PER_LINE, default 4, 32-bit words per line; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  IF stage requests a fetch at cpu_addr.
REQ-006 cpu_addr  input  32  byte address from the PC register; bits [1:0] are ignored.
REQ-007 cpu_instr  output  32  instruction word for cpu_addr; valid when cpu_req=1 and cpu_stall=0.
REQ-008 cpu_stall  output  1  freeze PC and IF/ID; fed to the hazard unit.
REQ-009 flush  input  1  invalidate all lines (fence.i).
REQ-010 mem_req  output  1  refill request to backing instruction memory.
REQ-011 mem_addr  output  32  line-aligned refill base address.
REQ-012 mem_valid  input  1  one refill beat is present on mem_rdata.
REQ-013 mem_rdata  input  32  refill beat data, delivered in ascending word order.

Function
REQ-014 Address split: offset = addr[1+log2(WPL):2]; index = next log2(NUM_LINES) bits; tag = remaining upper bits (24 bits at the defaults).
REQ-015 Hit: when state is IDLE, cpu_req=1, valid[index]=1 and tag matches, cpu_instr = data[index][offset] combinationally in the same cycle and cpu_stall=0.
REQ-016 Miss: when state is IDLE and cpu_req=1 without a hit, cpu_stall=1 in the same cycle; the next state is REFILL; cpu_addr is latched.
REQ-017 FSM states are IDLE and REFILL only. IDLE goes to REFILL on a miss. REFILL goes to IDLE on the clock edge that accepts the final beat.
REQ-018 In REFILL: mem_req=1, mem_addr = latched address with offset and bits [1:0] zeroed, and cpu_stall=1 every cycle.
REQ-019 Each mem_valid beat writes data[index][beat_cnt] and increments a beat counter, which runs 0..WPL-1 and resets to 0 on exit.
REQ-020 On the final beat, the line's tag is written and valid[index] is set, unless a flush is pending (see REQ-022).
REQ-021 Changes to cpu_addr or cpu_req during REFILL are ignored. After REFILL returns to IDLE, lookup is re-evaluated, so a refetch of the same address hits in the next cycle.
REQ-022 flush in IDLE clears all valid bits on that clock edge; a lookup in that same cycle still uses the pre-flush state. flush during REFILL sets a pending flag; at refill completion all valid bits clear, the refilled line is not marked valid, and the pending flag clears.
REQ-023 When cpu_req=0 in IDLE: cpu_stall=0 and mem_req=0.
REQ-024 mem_valid is ignored in IDLE.
REQ-025 Miss penalty with mem_valid asserted every cycle: miss cycle + WPL REFILL cycles + hit cycle = WPL+2 cycles from first request to instruction delivered.

Reset
REQ-026 rst clears all valid bits, the pending-flush flag and the beat counter, sets state to IDLE, and forces mem_req=0 and cpu_stall=0 whenever cpu_req=0.
REQ-027 rst asserted during REFILL aborts the refill on that edge: no partial line is left valid, and later beats are ignored.
REQ-028 Tag and data arrays are not reset. cpu_instr is don't-care unless REQ-015 holds.

Structure
REQ-029 A shared package icache_pkg holds the FSM state enum and the default NUM_LINES and WORDS_PER_LINE constants. Derived index, offset and tag widths are computed locally.
REQ-030 One sub-module, icache_data_array, holds the data storage: a word-write port (index, word, data) and an asynchronous read port. Tag and valid storage plus the FSM remain in instr_cache.
REQ-031 Integration: cpu_stall is ORed with the data-side stall at the hazard unit; PC and IF/ID hold while it is high.

Verification
REQ-032 After reset, fetch 0x0000_0000 with beats 0x00500093,0x00100113,0x002081B3,0x00000013 every cycle -> stall for 5 cycles, mem_addr=0x0000_0000, then cpu_instr=0x00500093 with stall=0; fetch 0x0C -> hit 0x00000013 with no stall.
REQ-033 Conflict: fetch 0x0000_0000, then 0x0000_0100 (same index 0, different tag) -> second fetch misses and refills; refetch of 0x0 misses again.
REQ-034 Slow memory: mem_valid every third cycle -> stall held throughout, beats placed in words 0..3 in order, final line contents correct.
REQ-035 Flush asserted during the 2nd beat of a refill for 0x40 -> refill completes and returns to IDLE; the next fetch of 0x40 misses; previously cached line 0x0 also misses.
REQ-036 rst pulsed during the 3rd beat of a refill for 0x80 -> mem_req drops next cycle; fetch 0x80 afterwards misses and refills from beat 0.
REQ-037 cpu_addr changed to 0x200 mid-refill of 0x10 -> mem_addr stays 0x10 until completion; the line for 0x10 is valid, then 0x200 misses.
